// File: rtl/saif_activity_pkg.sv
// rtl/saif_activity_pkg.sv - shared types and defaults for the SAIF activity counter
package saif_activity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DUMP  = 2'd2
    } state_e;

    // Default counter width; also the field width of act_rec_t, so it bounds CNT_W.
    localparam int CNT_W_DEF = 16;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] t1;
        logic [CNT_W_DEF-1:0] tc;
    } act_rec_t;

endpackage

// File: rtl/saif_bit_counter.sv
// rtl/saif_bit_counter.sv - per-bit high-time and toggle counters with saturation
module saif_bit_counter
    import saif_activity_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr,
    input  logic     en,
    input  logic     first,
    input  logic     sample,
    output act_rec_t rec
);

    logic [CNT_W-1:0] t1_q;
    logic [CNT_W-1:0] tc_q;
    logic             prev_q;

    // Clear on window open; while counting, accumulate high time and toggles.
    // The first counted cycle only seeds prev so it never registers a toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1_q   <= '0;
            tc_q   <= '0;
            prev_q <= 1'b0;
        end else if (clr) begin
            t1_q   <= '0;
            tc_q   <= '0;
            prev_q <= 1'b0;
        end else if (en) begin
            if (sample && (t1_q != '1)) begin
                t1_q <= t1_q + CNT_W'(1);
            end
            if (!first && (sample != prev_q) && (tc_q != '1)) begin
                tc_q <= tc_q + CNT_W'(1);
            end
            prev_q <= sample;
        end
    end

    assign rec.t1 = CNT_W_DEF'(t1_q);
    assign rec.tc = CNT_W_DEF'(tc_q);

endmodule

// File: rtl/saif_activity_counter.sv
// rtl/saif_activity_counter.sv - windowed per-bit switching-activity monitor (optional SAIF_ACTIVITY_T0_EN adds rd_t0)
module saif_activity_counter
    import saif_activity_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CNT_W = CNT_W_DEF,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] sample_in,
    output logic             busy,
    output logic [CNT_W-1:0] duration,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_t1,
    output logic [CNT_W-1:0] rd_tc,
`ifdef SAIF_ACTIVITY_T0_EN
    output logic [CNT_W-1:0] rd_t0,
`endif
    output logic             rd_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e           state;
    logic             first_q;
    logic             clr;
    logic             en;
    logic             hs;
    logic [IDX_W-1:0] idx_nxt;
    act_rec_t         recs [WIDTH];

    assign clr     = (state == IDLE) && start;
    assign en      = (state == COUNT);
    assign hs      = rd_valid && rd_ready;
    assign idx_nxt = rd_idx + IDX_W'(1);

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            saif_bit_counter #(
                .CNT_W (CNT_W)
            ) u_bit (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr    (clr),
                .en     (en),
                .first  (first_q),
                .sample (sample_in[g]),
                .rec    (recs[g])
            );
        end
    endgenerate

    // Window control FSM: IDLE -> COUNT on start, COUNT -> DUMP on stop,
    // DUMP walks one record per handshake and returns to IDLE after the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            first_q  <= 1'b0;
            busy     <= 1'b0;
            duration <= '0;
            rd_valid <= 1'b0;
            rd_idx   <= '0;
            rd_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COUNT;
                        first_q  <= 1'b1;
                        busy     <= 1'b1;
                        duration <= '0;
                    end
                end
                COUNT: begin
                    first_q <= 1'b0;
                    if (duration != '1) begin
                        duration <= duration + CNT_W'(1);
                    end
                    if (stop) begin
                        state    <= DUMP;
                        rd_valid <= 1'b1;
                        rd_idx   <= '0;
                        rd_last  <= (LAST_IDX == '0);
                    end
                end
                DUMP: begin
                    if (hs) begin
                        if (rd_last) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                            rd_idx   <= '0;
                        end else begin
                            rd_idx  <= idx_nxt;
                            rd_last <= (idx_nxt == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                end
            endcase
        end
    end

    // Record mux straight off the registered counters, selected by rd_idx.
    always_comb begin
        rd_t1 = '0;
        rd_tc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_t1 = recs[i].t1[CNT_W-1:0];
                rd_tc = recs[i].tc[CNT_W-1:0];
            end
        end
    end

`ifdef SAIF_ACTIVITY_T0_EN
    // Low time; T1 never exceeds duration since both saturate at the same ceiling.
    assign rd_t0 = duration - rd_t1;
`endif

endmodule

// File: doc/saif_activity_counter.md
Name: saif_activity_counter

Overview:
- Per-bit switching-activity monitor placed directly downstream of the traced test module; consumes its packed `state` output vector.
- Over a start/stop window, accumulates SAIF-style statistics per bit:
  - T1: cycles the bit was high.
  - TC: number of toggles.
  - Window duration.
- After stop, streams one record per bit over a valid/ready interface so the bench can cross-check the simulator's SAIF dump.

Parameters:
- WIDTH, 5, number of monitored bits (matches the 5-bit `state` vector).
- CNT_W, 16, width of the T1, TC and duration counters; all saturate.

Ports:
- clk  input  1  sampling clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that opens a window; honoured only in IDLE.
- stop  input  1  single-cycle pulse that closes a window; honoured only in COUNT.
- sample_in  input  WIDTH  monitored vector, sampled every cycle in COUNT.
- busy  output  1  high in COUNT and DUMP.
- duration  output  CNT_W  cycles sampled in the last or current window.
- rd_valid  output  1  record valid.
- rd_ready  input  1  consumer accepts the record.
- rd_idx  output  $clog2(WIDTH)  bit index of the record.
- rd_t1  output  CNT_W  T1 for bit rd_idx.
- rd_tc  output  CNT_W  TC for bit rd_idx.
- rd_last  output  1  marks the record for bit WIDTH-1.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - All counters, the prev register and rd_idx clear to 0.
  - busy, rd_valid and rd_last go to 0; duration goes to 0.
  - Reset asserted mid-window or mid-dump aborts immediately; no partial records.
- FSM states: IDLE, COUNT, DUMP.
- IDLE:
  - On start: clear all T1/TC/duration counters and go to COUNT.
  - The start-cycle sample is not counted.
  - stop is ignored.
  - start and stop asserted together: start wins.
- COUNT, every cycle:
  - duration += 1.
  - Per bit i: T1[i] += sample_in[i].
  - TC[i] += (sample_in[i] != prev[i]), but only from the second COUNT cycle onward. The first COUNT cycle loads prev without counting a toggle.
  - prev <= sample_in.
  - All counters saturate at 2^CNT_W-1; they never wrap.
  - start is ignored.
- stop in COUNT:
  - The stop-cycle sample is still counted.
  - Next state is DUMP, with rd_idx=0 and rd_valid=1 one cycle after stop.
- DUMP:
  - rd_valid stays high until the final handshake.
  - rd_idx, rd_t1, rd_tc and rd_last hold stable while rd_valid && !rd_ready.
  - On handshake: rd_idx += 1; after the handshake with rd_last=1, go to IDLE with rd_valid=0.
  - Back-to-back handshakes give one record per cycle, so minimum dump length is WIDTH cycles.
  - start and stop are ignored.
- Counter retention:
  - duration holds its value in IDLE until the next start.
  - T1/TC are readable only through DUMP.
- Outputs rd_t1/rd_tc are muxed from registered counters; the mux is combinational on rd_idx and adds no extra latency.

Optional Feature:
- Macro: SAIF_ACTIVITY_T0_EN.
- Defined:
  - Adds output port rd_t0 [CNT_W], equal to duration - T1[rd_idx], computed combinationally.
  - Subtraction is never negative, because T1 ≤ duration, and both saturate together.
- Undefined: port absent; no subtractor.

Decomposition:
- Package saif_activity_pkg holds:
  - state_e enum (IDLE, COUNT, DUMP).
  - Localparam default CNT_W.
  - Packed struct act_rec_t {t1, tc} of CNT_W each.
- Sub-module saif_bit_counter, instantiated WIDTH times via generate:
  - Inputs: clk, rst_n, clr, en, first, sample.
  - Outputs: the act_rec_t record.
  - Holds that bit's prev register and two saturating counters.

Test Plan:
- Reset: rst_n=0 mid-COUNT after 3 cycles -> busy=0, rd_valid=0, duration=0 immediately; next window starts clean.
- Basic window, WIDTH=5, sample_in = 5'b00000, 5'b00001, 5'b00011, 5'b00010 over 4 cycles, rd_ready=1:
  - duration=4.
  - Records: bit0 t1=2 tc=2; bit1 t1=2 tc=1; bits2-4 t1=0 tc=0.
  - rd_last only on idx 4.
- First sample not a toggle: sample_in=5'b11111 for 3 cycles -> every bit t1=3, tc=0.
- Backpressure: rd_ready low 3 cycles on idx 2 -> idx 2 record held stable; total 5 handshakes; rd_last on idx 4; returns to IDLE.
- Saturation with CNT_W=4: bit0 toggles every cycle for 20 cycles -> tc=15, t1=10, duration=15.
- Simultaneous events:
  - start+stop in IDLE -> enters COUNT.
  - start during DUMP -> ignored.
  - stop in IDLE -> no effect, rd_valid stays 0.
